// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 receiver: pin sync, clock glitch filter, framed byte
// reception with watchdog, and E0/F0 prefix decoding into held key levels.
module ps2_key_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_left,
  output logic       key_right,
  output logic       key_down,
  output logic       key_rotate,
  output logic       key_drop,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  // Start low, stop high, odd parity over data plus parity bit.
  function automatic logic frame_ok(input logic [10:0] f);
    return (f[0] == 1'b0) && (f[10] == 1'b1) && (^f[9:1] == 1'b1);
  endfunction

  logic [1:0]    clk_sync_r;
  logic [1:0]    data_sync_r;
  logic          filt_r;
  logic [FW-1:0] filt_cnt_r;
  logic          filt_flip_s;
  logic          fall_s;
  logic [3:0]    bit_cnt_r;
  logic [10:0]   shift_r;
  logic [10:0]   frame_s;
  logic [WW-1:0] wd_r;
  state_t        state_r;
  state_t        next_state_s;
  logic          next_left_s;
  logic          next_right_s;
  logic          next_down_s;
  logic          next_rotate_s;
  logic          next_drop_s;
  logic          make_s;
  logic          ext_s;

  // Two-flop synchronisers for both pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2_clk};
      data_sync_r <= {data_sync_r[0], ps2_data};
    end
  end

  // Flip decision for the glitch filter and the resulting fall strobe.
  always_comb begin
    filt_flip_s = (clk_sync_r[1] != filt_r) && (filt_cnt_r == FW'(FILTER_LEN - 1));
    fall_s      = filt_flip_s && filt_r;
    frame_s     = {data_sync_r[1], shift_r[10:1]};
  end

  // Filtered clock follows the synchronised clock after FILTER_LEN equal samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_r     <= 1'b1;
      filt_cnt_r <= '0;
    end else if (clk_sync_r[1] == filt_r) begin
      filt_cnt_r <= '0;
    end else if (filt_flip_s) begin
      filt_r     <= ~filt_r;
      filt_cnt_r <= '0;
    end else begin
      filt_cnt_r <= filt_cnt_r + FW'(1);
    end
  end

  // Bit receiver, frame checks and watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r  <= 4'd0;
      shift_r    <= 11'd0;
      wd_r       <= '0;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall_s) begin
        wd_r <= '0;
        if (bit_cnt_r == 4'd0) begin
          if (data_sync_r[1]) begin
            frame_err <= 1'b1;
          end else begin
            shift_r   <= frame_s;
            bit_cnt_r <= 4'd1;
          end
        end else if (bit_cnt_r == 4'd10) begin
          bit_cnt_r <= 4'd0;
          shift_r   <= frame_s;
          if (frame_ok(frame_s)) begin
            byte_valid <= 1'b1;
            byte_data  <= frame_s[8:1];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          shift_r   <= frame_s;
          bit_cnt_r <= bit_cnt_r + 4'd1;
        end
      end else if (bit_cnt_r != 4'd0) begin
        if (wd_r == WW'(TIMEOUT)) begin
          bit_cnt_r <= 4'd0;
          wd_r      <= '0;
          frame_err <= 1'b1;
        end else begin
          wd_r <= wd_r + WW'(1);
        end
      end else begin
        wd_r <= '0;
      end
    end
  end

  // Prefix FSM next state and key levels; non-prefix bytes always return to IDLE.
  always_comb begin
    next_state_s  = state_r;
    next_left_s   = key_left;
    next_right_s  = key_right;
    next_down_s   = key_down;
    next_rotate_s = key_rotate;
    next_drop_s   = key_drop;
    make_s        = (state_r == ST_IDLE) || (state_r == ST_EXT);
    ext_s         = (state_r == ST_EXT) || (state_r == ST_EXT_BRK);
    if (frame_err) begin
      next_state_s = ST_IDLE;
    end else if (byte_valid) begin
      case (byte_data)
        8'hE0: begin
          case (state_r)
            ST_IDLE: next_state_s = ST_EXT;
            ST_BRK:  next_state_s = ST_EXT_BRK;
            default: next_state_s = state_r;
          endcase
        end
        8'hF0: begin
          case (state_r)
            ST_IDLE: next_state_s = ST_BRK;
            ST_EXT:  next_state_s = ST_EXT_BRK;
            default: next_state_s = state_r;
          endcase
        end
        default: begin
          next_state_s = ST_IDLE;
          if (ext_s) begin
            case (byte_data)
              8'h6B:   next_left_s   = make_s;
              8'h74:   next_right_s  = make_s;
              8'h72:   next_down_s   = make_s;
              8'h75:   next_rotate_s = make_s;
              default: next_left_s   = key_left;
            endcase
          end else if (byte_data == 8'h29) begin
            next_drop_s = make_s;
          end else begin
            next_drop_s = key_drop;
          end
        end
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  // FSM state and registered key levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      key_left   <= 1'b0;
      key_right  <= 1'b0;
      key_down   <= 1'b0;
      key_rotate <= 1'b0;
      key_drop   <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      key_left   <= next_left_s;
      key_right  <= next_right_s;
      key_down   <= next_down_s;
      key_rotate <= next_rotate_s;
      key_drop   <= next_drop_s;
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: frames are bit-banged on the pins and
// expected bytes/errors queued, then matched against byte_valid/frame_err.
module tb_ps2_key_decoder;
  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 2000;
  localparam int HALF       = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_left, key_right, key_down, key_rotate, key_drop;
  logic       byte_valid, frame_err;
  logic [7:0] byte_data;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  ps2_key_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_left(key_left), .key_right(key_right), .key_down(key_down),
    .key_rotate(key_rotate), .key_drop(key_drop),
    .byte_valid(byte_valid), .byte_data(byte_data), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && (byte_valid || frame_err)) begin
      if (byte_valid && frame_err) check_eq("both_pulses", 32'd1, 32'd0);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_pulse", {23'd0, frame_err, byte_data}, 32'h1FF);
      end else begin
        check_eq("scoreboard", frame_err ? 32'h100 : {24'd0, byte_data}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk) ps2_data = b;
    repeat (HALF / 2) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF / 2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    exp_q.push_back((bad_par || bad_stop) ? 9'h100 : {1'b0, b});
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(~bad_stop);
    ps2_data = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
  endtask

  task automatic check_keys(input string tag, input logic [4:0] exp);
    check_eq(tag, {27'd0, key_left, key_right, key_down, key_rotate, key_drop}, {27'd0, exp});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_keys("reset_keys", 5'b00000);
    check_eq("reset_bytes", {22'd0, byte_valid, frame_err, byte_data}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Space make/break
    send(8'h29);
    check_keys("drop_make", 5'b00001);
    send(8'hF0); send(8'h29);
    check_keys("drop_break", 5'b00000);

    // Extended arrows
    send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'h74);
    check_keys("left_right_make", 5'b11000);
    send(8'hE0); send(8'hF0); send(8'h6B);
    check_keys("left_break", 5'b01000);
    send(8'hE0); send(8'hF0); send(8'h74);
    check_keys("right_break", 5'b00000);

    // Keypad 6B and E0 29 are ignored
    send(8'h6B);
    check_keys("keypad_ignored", 5'b00000);
    send(8'hE0); send(8'h29);
    check_keys("e0_29_ignored", 5'b00000);

    // Corruptions
    send_frame(8'h75, 1'b1, 1'b0);
    send(8'h29);
    check_keys("after_bad_parity", 5'b00001);
    send_frame(8'hF0, 1'b0, 1'b1);
    send(8'h29);
    check_keys("after_bad_stop", 5'b00001);
    send(8'hE0);
    send_frame(8'h11, 1'b1, 1'b0);
    send(8'h75);
    check_keys("prefix_dropped", 5'b00001);
    send(8'hF0); send(8'h29);
    check_keys("drop_cleared", 5'b00000);

    // Watchdog on a 5-bit partial frame
    exp_q.push_back(9'h100);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (TIMEOUT + 100) @(negedge clk);
    check_eq("timeout_drained", exp_q.size(), 32'd0);
    send(8'hE0); send(8'h72);
    check_keys("down_after_timeout", 5'b00100);

    // Short clock glitches are filtered out
    for (int g = 0; g < 6; g++) begin
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (12) @(negedge clk);
    end
    check_keys("glitch_no_change", 5'b00100);
    send(8'hE0); send(8'hF0); send(8'h72);
    check_keys("down_break", 5'b00000);

    // Async reset mid-frame
    send(8'hE0); send(8'h6B);
    check_keys("left_before_reset", 5'b10000);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_keys("async_reset_keys", 5'b00000);
    check_eq("async_reset_bytes", {22'd0, byte_valid, frame_err, byte_data}, 32'd0);
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    send(8'h29);
    check_keys("post_reset_drop", 5'b00001);

    check_eq("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives PS/2 scan-code set 2 frames from the keyboard pins and maintains one held/released level per game key. Sits directly upstream of the input manager: its `key_*` outputs drive that block's `raw_*` level inputs. It handles pin synchronisation, clock-glitch filtering, frame reception with parity/framing checks, a frame watchdog, and E0/F0 prefix decoding.

## Interface
- `FILTER_LEN`, 8: consecutive equal synchronised samples required before the filtered PS/2 clock changes state.
- `TIMEOUT`, 50000: clk cycles without a filtered falling edge before a partial frame is abandoned (1 ms at 50 MHz).
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous.
- `key_left`  out  1  level; Left arrow (E0 6B) held.
- `key_right`  out  1  level; Right arrow (E0 74) held.
- `key_down`  out  1  level; Down arrow (E0 72) held.
- `key_rotate`  out  1  level; Up arrow (E0 75) held.
- `key_drop`  out  1  level; Space (29) held.
- `byte_valid`  out  1  one-cycle pulse; a good byte was received.
- `byte_data`  out  8  last good byte; held until the next good byte.
- `frame_err`  out  1  one-cycle pulse; parity, start, stop or timeout error.

## Operation
- Input stage: each pin passes through 2 flops. The filtered clock takes the synchronised value after FILTER_LEN consecutive identical samples. A fall strobe is generated on the cycle the filtered clock goes 1→0. The filter resets to 1 (idle high).
- Receiver: bit counter 0..10 plus an 11-bit shift register. Each fall strobe samples synchronised data.
  - Bit 0 is the start bit and must be 0.
  - Bits 1–8 are data, LSB first.
  - Bit 9 is parity; the XOR of data and parity must be 1 (odd).
  - Bit 10 is the stop bit and must be 1.
- After bit 10, the counter returns to 0.
  - A good frame pulses `byte_valid` and updates `byte_data`.
  - A bad frame pulses `frame_err` only.
- A start bit sampled as 1 is rejected immediately: the counter stays 0 and `frame_err` pulses.
- Watchdog: the counter counts cycles while the bit counter ≠ 0 and restarts on every fall strobe. When it reaches TIMEOUT, the bit counter resets to 0 and `frame_err` pulses. The watchdog is idle while the bit counter = 0.
- Decoder FSM acts on good bytes only. States: IDLE, EXT, BRK, EXT_BRK.
  - E0 byte: IDLE→EXT, BRK→EXT_BRK, EXT and EXT_BRK unchanged.
  - F0 byte: IDLE→BRK, EXT→EXT_BRK, BRK and EXT_BRK unchanged.
  - Any other byte: apply it and return to IDLE. Make codes (IDLE/EXT) set the key level to 1; break codes (BRK/EXT_BRK) set it to 0.
- Key mapping:
  - Arrow codes 6B/74/72/75 map only in EXT or EXT_BRK. Non-extended 6B/74/72/75 are keypad keys and are ignored.
  - 29 maps only in IDLE or BRK. E0 29 is ignored.
  - Unmapped codes (including AA, FA, FE, E1) cause no key change but still return the FSM to IDLE.
- Any `frame_err` forces the FSM to IDLE. Key levels are not changed by errors.
- Typematic repeats (make code resent while held) rewrite 1 to an already-1 key; no visible change.

## Timing
- Reset (async assert, synchronous deassertion handled upstream):
  - All `key_*` = 0, `byte_valid` = 0, `byte_data` = 00, `frame_err` = 0.
  - FSM = IDLE, bit counter = 0, watchdog = 0, filtered clock = 1.
  - Assertion mid-frame discards the partial frame and prefix state.
- Pin to strobe: a `ps2_clk` fall that stays low is recognised as a fall strobe 2 + FILTER_LEN cycles after the first low synchronised sample point. Pulses shorter than FILTER_LEN cycles are never seen.
- Stop-bit strobe at cycle T:
  - `byte_valid`/`byte_data`/`frame_err` register at T+1.
  - Key outputs and FSM update at T+2.
- Watchdog-at-TIMEOUT at cycle T gives a `frame_err` pulse at T+1.
- `byte_valid` and `frame_err` are never high in the same cycle. Each is exactly one cycle wide.
- Data is sampled from the same synchronised stage as the clock. There is no extra data delay.

## Test plan
- Reset, then send the frame 29 (data 0x29, parity 0) → `byte_valid` pulse with `byte_data`=29; `key_drop`=1 two cycles after the stop strobe. Then send F0, 29 → `key_drop`=0; no other key changes.
- Send E0 6B, then E0 74 → `key_left`=1 and `key_right`=1 together. Then E0 F0 6B → `key_left`=0, `key_right` stays 1. FSM in IDLE after each sequence.
- Send non-extended 6B (keypad 4) → `byte_valid` pulses, all `key_*` remain 0. Send E0 29 → `key_drop` remains 0.
- Corruptions, each followed by a good frame:
  - Frame 75 with wrong parity → `frame_err` pulse, no `byte_valid`.
  - Frame with stop bit = 0 → `frame_err`.
  - Preceded by E0: E0, bad-parity frame, then 75 → `key_rotate` stays 0 (prefix dropped).
- Send 5 bits, then idle TIMEOUT cycles → one `frame_err` pulse, bit counter back to 0. The next complete E0 72 frame sets `key_down`=1.
- Inject 3-cycle low glitches on `ps2_clk` with FILTER_LEN=8 → no strobes, no `byte_valid`. Assert `rst_n`=0 mid-frame while `key_left`=1 → all outputs 0 immediately (async).
